// File: rtl/btn_pkg.sv
// Shared definitions for push-button conditioning: FSM encoding, width helper
// and default 25 MHz timing.
package btn_pkg;

   typedef logic [1:0] btn_state_t;

   localparam btn_state_t StReleased   = 2'd0;
   localparam btn_state_t StPressChk   = 2'd1;
   localparam btn_state_t StPressed    = 2'd2;
   localparam btn_state_t StReleaseChk = 2'd3;

   localparam int unsigned DEF_SYNC_STAGES     = 2;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 250000;    // 10 ms
   localparam int unsigned DEF_REPEAT_DELAY    = 12500000;  // 500 ms
   localparam int unsigned DEF_REPEAT_PERIOD   = 2500000;   // 100 ms

   // Bits needed to hold values 0 .. v-1.
   function automatic int unsigned clog2(input longint unsigned v);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 63; i++) begin
         if ((64'd1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/btn_sync.sv
// Multi-flop synchroniser for an asynchronous pad; clears to 0 on reset.
module btn_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) chain_q <= '0;
      else     chain_q <= {chain_q[STAGES-2:0], d};
   end

   assign q = chain_q[STAGES-1];

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner: synchronise, debounce, and generate press/release
// and typematic auto-repeat strobes in the pixel-clock domain.
module btn_conditioner
   import btn_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter bit          ACTIVE_LOW      = 1'b0
) (
   input  logic CLK_25MHZ,
   input  logic RESET,
   input  logic BTN_RAW,
   output logic BTN,
   output logic BTN_PRESS,
   output logic BTN_RELEASE,
   output logic BTN_REPEAT
);

   localparam int unsigned CNT_W   = clog2(longint'(DEBOUNCE_CYCLES) + 1);
   localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                    : REPEAT_PERIOD;
   localparam int unsigned RPT_W   = clog2(longint'(RPT_MAX) + 1);

   logic raw_pol;
   logic sync_lvl;

   // Invert before the synchroniser so its reset value means "not pressed".
   assign raw_pol = ACTIVE_LOW ? ~BTN_RAW : BTN_RAW;

   btn_sync #(
      .STAGES(SYNC_STAGES)
   ) u_sync (
      .clk(CLK_25MHZ),
      .rst(RESET),
      .d  (raw_pol),
      .q  (sync_lvl)
   );

   btn_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [RPT_W-1:0]  rpt_q, rpt_d;
   logic [RPT_W-1:0]  rpt_inc, rpt_lim;
   logic              first_q, first_d;
   logic              btn_q, btn_d;
   logic              press_q, press_d;
   logic              release_q, release_d;
   logic              repeat_q, repeat_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rpt_d     = rpt_q;
      first_d   = first_q;
      btn_d     = btn_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      repeat_d  = 1'b0;
      rpt_inc   = rpt_q + RPT_W'(1);
      rpt_lim   = first_q ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_PERIOD);

      case (state_q)
         StReleased: begin
            btn_d = 1'b0;
            if (sync_lvl) begin
               state_d = StPressChk;
               cnt_d   = CNT_W'(1);
            end
         end
         StPressChk: begin
            if (!sync_lvl) begin
               state_d = StReleased;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
               state_d = StPressed;
               btn_d   = 1'b1;
               press_d = 1'b1;
               rpt_d   = '0;
               first_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StPressed: begin
            // Leaving PRESSED takes priority, so a repeat due now is dropped.
            if (!sync_lvl) begin
               state_d = StReleaseChk;
               cnt_d   = CNT_W'(1);
            end else if (REPEAT_DELAY != 0) begin
               if (rpt_inc == rpt_lim) begin
                  repeat_d = 1'b1;
                  rpt_d    = '0;
                  first_d  = 1'b0;
               end else begin
                  rpt_d = rpt_inc;
               end
            end
         end
         StReleaseChk: begin
            if (sync_lvl) begin
               state_d = StPressed;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
               state_d   = StReleased;
               btn_d     = 1'b0;
               release_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = StReleased;
            btn_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK_25MHZ or posedge RESET) begin
      if (RESET) begin
         state_q   <= StReleased;
         cnt_q     <= '0;
         rpt_q     <= '0;
         first_q   <= 1'b0;
         btn_q     <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         repeat_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rpt_q     <= rpt_d;
         first_q   <= first_d;
         btn_q     <= btn_d;
         press_q   <= press_d;
         release_q <= release_d;
         repeat_q  <= repeat_d;
      end
   end

   assign BTN         = btn_q;
   assign BTN_PRESS   = press_q;
   assign BTN_RELEASE = release_q;
   assign BTN_REPEAT  = repeat_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: three instances (active-high, active-low,
// repeat disabled) checked per cycle against a behavioural model.
module tb_btn_conditioner;

   localparam int unsigned S  = 2;
   localparam int unsigned D  = 4;
   localparam int unsigned RD = 10;
   localparam int unsigned RP = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic raw = 1'b0;
   logic raw_n;
   logic btn_m, prs_m, rls_m, rep_m;
   logic btn_a, prs_a, rls_a, rep_a;
   logic btn_n, prs_n, rls_n, rep_n;

   assign raw_n = ~raw;

   always #5 clk = ~clk;

   btn_conditioner #(
      .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
      .ACTIVE_LOW(1'b0)
   ) u_main (
      .CLK_25MHZ(clk), .RESET(rst), .BTN_RAW(raw),
      .BTN(btn_m), .BTN_PRESS(prs_m), .BTN_RELEASE(rls_m), .BTN_REPEAT(rep_m)
   );

   btn_conditioner #(
      .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
      .ACTIVE_LOW(1'b1)
   ) u_alow (
      .CLK_25MHZ(clk), .RESET(rst), .BTN_RAW(raw_n),
      .BTN(btn_a), .BTN_PRESS(prs_a), .BTN_RELEASE(rls_a), .BTN_REPEAT(rep_a)
   );

   btn_conditioner #(
      .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(0), .REPEAT_PERIOD(RP),
      .ACTIVE_LOW(1'b0)
   ) u_norpt (
      .CLK_25MHZ(clk), .RESET(rst), .BTN_RAW(raw),
      .BTN(btn_n), .BTN_PRESS(prs_n), .BTN_RELEASE(rls_n), .BTN_REPEAT(rep_n)
   );

   typedef struct packed {
      logic btn;
      logic press;
      logic rls;
      logic rpt;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   // Model: the level flips once D+1 consecutive opposite samples arrive;
   // repeats fall on hold counts RD, RD+RP, RD+2*RP, ...
   bit sq[$];
   bit m_btn;
   int m_run;
   int m_hold;

   function automatic void chk(input string name, input logic [3:0] act,
                               input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      sq = {};
      for (int i = 0; i < int'(S); i++) sq.push_back(1'b0);
      m_btn  = 1'b0;
      m_run  = 0;
      m_hold = 0;
   endfunction

   function automatic void model_edge(input bit r);
      bit   s;
      exp_t e;
      s = sq[S-1];
      void'(sq.pop_back());
      sq.push_front(r);
      e = '0;
      if (s != m_btn) begin
         m_run++;
         if (m_run == int'(D) + 1) begin
            m_btn = s;
            m_run = 0;
            if (s) begin
               e.press = 1'b1;
               m_hold  = 0;
            end else begin
               e.rls = 1'b1;
            end
         end
      end else begin
         if (m_btn && m_run == 0) begin
            m_hold++;
            if (m_hold >= int'(RD) && (m_hold - int'(RD)) % int'(RP) == 0) e.rpt = 1'b1;
         end
         m_run = 0;
      end
      e.btn = m_btn;
      exp_q.push_back(e);
   endfunction

   task automatic tick(input bit r);
      raw = r;
      @(posedge clk);
      if (!rst) model_edge(r);
      #2;
   endtask

   task automatic hold(input bit r, input int n);
      for (int i = 0; i < n; i++) tick(r);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("main", {btn_m, prs_m, rls_m, rep_m}, e);
         chk("active_low", {btn_a, prs_a, rls_a, rep_a}, e);
         chk("no_repeat", {btn_n, prs_n, rls_n, rep_n}, {e.btn, e.press, e.rls, 1'b0});
         chk("exclusive", {3'b000, ($countones({prs_m, rls_m, rep_m}) <= 1)}, 4'b0001);
      end
   end

   initial begin
      logic [3:0] want;
      int         run_len;
      bit         rv;

      repeat (3) @(posedge clk);
      #2;
      chk("reset_out", {btn_m, prs_m, rls_m, rep_m}, 4'b0000);
      rst = 1'b0;
      model_reset();
      hold(1'b0, 5);

      // Clean press and auto-repeat cadence from the first sampling edge.
      for (int i = 1; i <= 25; i++) begin
         tick(1'b1);
         want = {(i >= 7), (i == 7), 1'b0, (i == 17 || i == 20 || i == 23)};
         chk("press_repeat", {btn_m, prs_m, rls_m, rep_m}, want);
      end

      // Clean release.
      for (int k = 1; k <= 9; k++) begin
         tick(1'b0);
         chk("release", {btn_m, 1'b0, rls_m, 1'b0}, {(k < 7), 1'b0, (k == 7), 1'b0});
      end

      // Short bounce: nothing may change.
      for (int k = 1; k <= 11; k++) begin
         tick(k <= 3);
         chk("bounce", {btn_m, prs_m, rls_m, 1'b0}, 4'b0000);
      end

      // Press with a one-edge gap restarts debouncing after the gap.
      hold(1'b1, 3);
      tick(1'b0);
      for (int j = 1; j <= 10; j++) begin
         tick(1'b1);
         chk("gap_press", {btn_m, prs_m, 2'b00}, {(j >= 7), (j == 7), 2'b00});
      end

      // Long hold for the repeat-disabled instance, then a release glitch.
      hold(1'b1, 100);
      hold(1'b0, 2);
      for (int j = 1; j <= 20; j++) begin
         tick(1'b1);
         chk("rel_glitch", {btn_m, 1'b0, rls_m, 1'b0}, 4'b1000);
      end
      hold(1'b0, 10);

      // Randomised runs.
      for (int n = 0; n < 60; n++) begin
         rv      = 1'($urandom_range(0, 1));
         run_len = int'($urandom_range(1, 9));
         hold(rv, run_len);
      end

      // Asynchronous reset while pressed, released with the button held.
      hold(1'b1, 20);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("async_rst_main", {btn_m, prs_m, rls_m, rep_m}, 4'b0000);
      chk("async_rst_alow", {btn_a, prs_a, rls_a, rep_a}, 4'b0000);
      chk("async_rst_norpt", {btn_n, prs_n, rls_n, rep_n}, 4'b0000);
      exp_q = {};
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      model_reset();
      for (int j = 1; j <= 8; j++) begin
         tick(1'b1);
         chk("post_rst_press", {btn_m, prs_m, 2'b00}, {(j >= 7), (j == 7), 2'b00});
      end
      hold(1'b0, 12);

      @(negedge clk);
      #1;
      chk("drained", {3'b000, (exp_q.size() == 0)}, 4'b0001);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
